pu_fetch_ctrl: RTL and testbench

Instruction fetch sequencer for the packet processing unit core. Fetches 32-bit RISC-V instructions from instruction memory starting at a programmed PC and buffers them in a 2-entry FIFO. Presents them with a valid/ready handshake to the decode/execute stage. Runs in order with no speculation: fetch stops after every control-flow instruction until execute returns the next PC, and stops for good on the SYSTEM (end-of-program) opcode.

---
 rtl/pu_fetch_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_pu_fetch_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_fetch_ctrl.sv
// Instruction fetch sequencer: in-order fetch into a 2-entry FIFO, stalls on
// control flow until execute resolves the next PC, stops on the SYSTEM opcode.
module pu_fetch_ctrl #(
  parameter int IN_WIDTH = 32,
  parameter int PC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [PC_WIDTH-1:0] start_pc,
  input  logic                flush,
  output logic                imem_rd,
  output logic [PC_WIDTH-3:0] imem_addr,
  input  logic [IN_WIDTH-1:0] imem_rdata,
  output logic [IN_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0] inst_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  input  logic                resolve_valid,
  input  logic [PC_WIDTH-1:0] resolve_pc,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic                is_end;
    logic [PC_WIDTH-1:0] pc;
    logic [IN_WIDTH-1:0] ins;
  } entry_t;

  localparam logic [PC_WIDTH-1:0] PC_MASK = {{(PC_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  function automatic logic op_is_cf(input logic [4:0] op);
    return (op == 5'b11000) || (op == 5'b11011) || (op == 5'b11001);
  endfunction

  function automatic logic op_is_end(input logic [4:0] op);
    return (op == 5'b11100);
  endfunction

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] rd_pc_q, rd_pc_d;
  logic                inflight_q, inflight_d;
  logic                squash_q, squash_d;
  logic [1:0]          cnt_q, cnt_d;
  entry_t              e0_q, e0_d, e1_q, e1_d;
  logic                done_q, done_d;

  logic [4:0]          op;
  logic                capture, cap_cf, cap_end, pop, issue;
  logic [2:0]          occ;
  entry_t              new_e;

  // Next-state, FIFO and read-issue logic
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rd_pc_d    = rd_pc_q;
    cnt_d      = cnt_q;
    e0_d       = e0_q;
    e1_d       = e1_q;
    done_d     = 1'b0;
    squash_d   = 1'b0;

    op         = imem_rdata[6:2];
    capture    = inflight_q & ~squash_q;
    cap_cf     = capture & op_is_cf(op);
    cap_end    = capture & op_is_end(op);
    new_e      = '{is_end: op_is_end(op), pc: rd_pc_q, ins: imem_rdata};
    pop        = (cnt_q != 2'd0) & inst_ready;
    // Occupancy counts the slot freed by this cycle's pop so a steady stream
    // keeps one read in flight every cycle.
    occ        = {1'b0, cnt_q} - {2'b00, pop} + {2'b00, inflight_q};
    issue      = (state_q == ST_FETCH) & ~flush & (occ < 3'd2);
    inflight_d = issue;

    if (issue) begin
      pc_d    = pc_q + PC_STEP;
      rd_pc_d = pc_q;
    end else begin
      rd_pc_d = rd_pc_q;
    end

    if (capture && pop) begin
      if (cnt_q == 2'd2) begin
        e0_d = e1_q;
        e1_d = new_e;
      end else begin
        e0_d = new_e;
      end
    end else if (capture) begin
      if (cnt_q == 2'd0) begin
        e0_d = new_e;
      end else begin
        e1_d = new_e;
      end
      cnt_d = cnt_q + 2'd1;
    end else if (pop) begin
      e0_d  = e1_q;
      cnt_d = cnt_q - 2'd1;
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = start_pc & PC_MASK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // The read issued alongside a CF/END capture is past the stop point.
        if (cap_cf || cap_end) begin
          state_d  = cap_cf ? ST_WAIT : ST_DRAIN;
          pc_d     = rd_pc_q + PC_STEP;
          squash_d = issue;
        end else begin
          state_d  = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (resolve_valid) begin
          state_d = ST_FETCH;
          pc_d    = resolve_pc & PC_MASK;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (pop && e0_q.is_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (flush) begin
      state_d    = ST_IDLE;
      cnt_d      = 2'd0;
      inflight_d = 1'b0;
      squash_d   = 1'b0;
      done_d     = 1'b0;
    end else begin
      cnt_d      = cnt_d;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      rd_pc_q    <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
      cnt_q      <= 2'd0;
      e0_q       <= '0;
      e1_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rd_pc_q    <= rd_pc_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
      cnt_q      <= cnt_d;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
      done_q     <= done_d;
    end
  end

  assign imem_rd    = issue;
  assign imem_addr  = pc_q[PC_WIDTH-1:2];
  assign inst       = e0_q.ins;
  assign inst_pc    = e0_q.pc;
  assign inst_valid = (cnt_q != 2'd0);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_pu_fetch_ctrl.sv
// Directed bench for pu_fetch_ctrl: straight line, backpressure, branch,
// flush, PC wrap and mid-run reset, checked against hand-derived cycles.
module tb_pu_fetch_ctrl;
  localparam int IW = 32;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] start_pc = '0;
  logic          flush = 1'b0;
  logic          imem_rd;
  logic [PW-3:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] inst;
  logic [PW-1:0] inst_pc;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic          resolve_valid = 1'b0;
  logic [PW-1:0] resolve_pc = '0;
  logic          busy;
  logic          done;

  logic [31:0]   mem [0:16383];
  int            n_checks = 0;
  int            n_errors = 0;
  int            n_rd = 0;
  int            n_done = 0;
  logic [15:0]   acc_q[$];
  logic [15:0]   exp_q[$];

  always #5 clk = ~clk;

  pu_fetch_ctrl #(.IN_WIDTH(IW), .PC_WIDTH(PW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .start_pc(start_pc), .flush(flush),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .busy(busy), .done(done)
  );

  // Instruction memory: one-cycle read latency, junk when not read
  always @(posedge clk) imem_rdata <= imem_rd ? mem[imem_addr] : 32'hDEADBEEF;

  // Event monitor, sampled mid-cycle after inputs have settled
  always @(negedge clk) begin
    #2;
    if (rstn) begin
      if (imem_rd) n_rd++;
      if (done) n_done++;
      if (inst_valid && inst_ready) acc_q.push_back(inst_pc);
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_pulse(input logic [PW-1:0] pc);
    @(negedge clk); start = 1'b1; start_pc = pc;
    @(negedge clk); start = 1'b0; #1;
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    logic found;
    found = 1'b0;
    for (int k = 0; k < maxc && !found; k++) begin
      @(negedge clk); #1;
      if (done) found = 1'b1;
    end
    check_eq({tag, "_done_seen"}, {31'd0, found}, 32'd1);
    check_eq({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    step(); step();
    check_eq({tag, "_done_count"}, n_done, 32'd1);
  endtask

  task automatic check_seq(input string tag);
    check_eq({tag, "_len"}, acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check_eq($sformatf("%s_pc%0d", tag, i),
               (i < acc_q.size()) ? {16'd0, acc_q[i]} : 32'hFFFFFFFF, {16'd0, exp_q[i]});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_imem_rd"}, {31'd0, imem_rd}, 32'd0);
    check_eq({tag, "_imem_addr"}, {18'd0, imem_addr}, 32'd0);
    check_eq({tag, "_inst"}, inst, 32'd0);
    check_eq({tag, "_inst_pc"}, {16'd0, inst_pc}, 32'd0);
    check_eq({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic clear_run();
    acc_q.delete(); n_done = 0; n_rd = 0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h00000013;
    mem[16'h110 >> 2] = 32'h00000073;

    repeat (3) @(negedge clk);
    #1; check_reset_outputs("rst");
    @(negedge clk); rstn = 1'b1; #1;
    check_eq("rst_rel_busy", {31'd0, busy}, 32'd0);

    // Straight line, full throughput
    inst_ready = 1'b1; clear_run();
    start_pulse(16'h0100);
    check_eq("sl_t1_busy", {31'd0, busy}, 32'd1);
    check_eq("sl_t1_rd", {31'd0, imem_rd}, 32'd1);
    check_eq("sl_t1_addr", {18'd0, imem_addr}, 32'h40);
    check_eq("sl_t1_valid", {31'd0, inst_valid}, 32'd0);
    step();
    check_eq("sl_t2_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("sl_t2_addr", {18'd0, imem_addr}, 32'h41);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq($sformatf("sl_valid%0d", i), {31'd0, inst_valid}, 32'd1);
      check_eq($sformatf("sl_pc%0d", i), {16'd0, inst_pc}, 32'h100 + 32'(4 * i));
    end
    check_eq("sl_end_inst", inst, 32'h00000073);
    check_eq("sl_end_no_rd", {31'd0, imem_rd}, 32'd0);
    check_eq("sl_end_busy", {31'd0, busy}, 32'd1);
    check_eq("sl_end_done0", {31'd0, done}, 32'd0);
    step();
    check_eq("sl_done", {31'd0, done}, 32'd1);
    check_eq("sl_busy_fall", {31'd0, busy}, 32'd0);
    check_eq("sl_fifo_empty", {31'd0, inst_valid}, 32'd0);
    step();
    check_eq("sl_done_one_cycle", {31'd0, done}, 32'd0);
    step();
    check_eq("sl_done_count", n_done, 32'd1);
    exp_q = '{16'h100, 16'h104, 16'h108, 16'h10C, 16'h110};
    check_seq("sl");

    // Backpressure, with a stray resolve_valid that must be ignored
    inst_ready = 1'b0; clear_run();
    start_pulse(16'h0100);
    step();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      resolve_valid = (k == 2); resolve_pc = 16'h0500;
      #1;
      check_eq($sformatf("bp_valid%0d", k), {31'd0, inst_valid}, 32'd1);
      check_eq($sformatf("bp_head%0d", k), {16'd0, inst_pc}, 32'h100);
      check_eq($sformatf("bp_no_rd%0d", k), {31'd0, imem_rd}, 32'd0);
    end
    check_eq("bp_reads", n_rd, 32'd2);
    @(negedge clk); inst_ready = 1'b1;
    wait_done("bp", 30);
    check_seq("bp");

    // Branch at 0x104, resolved to 0x200 five cycles after acceptance
    mem[16'h104 >> 2] = 32'h00000063;
    mem[16'h204 >> 2] = 32'h00000073;
    clear_run();
    start_pulse(16'h0100);
    step();
    step();
    check_eq("br_head0", {16'd0, inst_pc}, 32'h100);
    step();
    check_eq("br_head1", {16'd0, inst_pc}, 32'h104);
    check_eq("br_inst", inst, 32'h00000063);
    check_eq("br_stall_rd0", {31'd0, imem_rd}, 32'd0);
    for (int k = 1; k < 5; k++) begin
      step();
      check_eq($sformatf("br_stall_rd%0d", k), {31'd0, imem_rd}, 32'd0);
      check_eq($sformatf("br_stall_valid%0d", k), {31'd0, inst_valid}, 32'd0);
    end
    @(negedge clk); resolve_valid = 1'b1; resolve_pc = 16'h0202; #1;
    check_eq("br_res_rd", {31'd0, imem_rd}, 32'd0);
    @(negedge clk); resolve_valid = 1'b0; #1;
    check_eq("br_after_rd", {31'd0, imem_rd}, 32'd1);
    check_eq("br_after_addr", {18'd0, imem_addr}, 32'h80);
    step();
    step();
    check_eq("br_tgt_valid", {31'd0, inst_valid}, 32'd1);
    check_eq("br_tgt_pc", {16'd0, inst_pc}, 32'h200);
    wait_done("br", 20);
    exp_q = '{16'h100, 16'h104, 16'h200, 16'h204};
    check_seq("br");
    mem[16'h104 >> 2] = 32'h00000013;

    // Flush with two entries buffered, then flush+start in IDLE, then restart
    inst_ready = 1'b0; clear_run();
    start_pulse(16'h0100);
    step();
    step();
    @(negedge clk); flush = 1'b1; #1;
    check_eq("fl_pre_valid", {31'd0, inst_valid}, 32'd1);
    @(negedge clk); flush = 1'b0; #1;
    check_eq("fl_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("fl_busy", {31'd0, busy}, 32'd0);
    check_eq("fl_done", {31'd0, done}, 32'd0);
    check_eq("fl_rd", {31'd0, imem_rd}, 32'd0);
    step(); step();
    check_eq("fl_no_done", n_done, 32'd0);
    @(negedge clk); flush = 1'b1; start = 1'b1; start_pc = 16'h0300;
    @(negedge clk); flush = 1'b0; start = 1'b0; #1;
    check_eq("fs_busy", {31'd0, busy}, 32'd0);
    check_eq("fs_rd", {31'd0, imem_rd}, 32'd0);
    mem[16'h304 >> 2] = 32'h00000073;
    inst_ready = 1'b1; clear_run();
    start_pulse(16'h0300);
    check_eq("fr_addr", {18'd0, imem_addr}, 32'hC0);
    step(); step();
    check_eq("fr_first_pc", {16'd0, inst_pc}, 32'h300);
    wait_done("fr", 20);
    exp_q = '{16'h300, 16'h304};
    check_seq("fr");

    // PC wrap at the top of the address space
    mem[16'h3FFF] = 32'h00000013;
    mem[0] = 32'h00000073;
    clear_run();
    start_pulse(16'hFFFC);
    check_eq("wr_addr0", {18'd0, imem_addr}, 32'h3FFF);
    step();
    check_eq("wr_addr1", {18'd0, imem_addr}, 32'h0000);
    step();
    check_eq("wr_pc0", {16'd0, inst_pc}, 32'hFFFC);
    step();
    check_eq("wr_pc1", {16'd0, inst_pc}, 32'h0000);
    check_eq("wr_inst1", inst, 32'h00000073);
    wait_done("wr", 20);

    // Reset mid-program with start held during reset
    clear_run();
    start_pulse(16'h0100);
    @(negedge clk); rstn = 1'b0; start = 1'b1; start_pc = 16'h0300; #1;
    @(negedge clk); rstn = 1'b1; start = 1'b0; #1;
    check_reset_outputs("mr");
    step();
    check_eq("mr_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("mr_busy", {31'd0, busy}, 32'd0);
    check_eq("mr_rd", {31'd0, imem_rd}, 32'd0);
    clear_run();
    start_pulse(16'h0100);
    wait_done("mr", 30);
    exp_q = '{16'h100, 16'h104, 16'h108, 16'h10C, 16'h110};
    check_seq("mr");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
